// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset defaults and
// opcode constants used jointly with the control unit.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC selection: sequential, taken branch or jump,
// with jump taking priority over branch.
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign jmp_tgt  = {pc_plus4[31:28], jump_target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)                next_pc = jmp_tgt;
    else if (branch && zero) next_pc = br_tgt;
    next_pc = word_align(next_pc);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one word fetch per instruction, holds the fetched word
// until downstream accepts it, then advances the PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [15:0] branch_imm,
  input  logic        Jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;

  next_pc_calc u_next_pc (
    .pc          (pc_q),
    .branch      (Branch),
    .zero        (Zero),
    .branch_imm  (branch_imm),
    .jump        (Jump),
    .jump_target (jump_target),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  // Control inputs are only looked at on acceptance (HOLD and !stall).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    imem_req = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= word_align(RESET_PC);
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instruction = instr_valid ? instr_q : NOP_INSTR;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL expose parameter NOP_INSTR, default 32'h0000_0000, the instruction value driven whenever instr_valid is low.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the fetch, always word aligned.
REQ-007 imem_rdata  input  32  instruction word, valid in the cycle imem_ready is high.
REQ-008 imem_ready  input  1  memory completion strobe, sampled only while imem_req is high.
REQ-009 stall  input  1  downstream hold; while high, the presented instruction SHALL NOT be consumed.
REQ-010 Branch  input  1  branch decode for the presented instruction.
REQ-011 Zero  input  1  ALU equality result for the presented instruction.
REQ-012 branch_imm  input  16  signed word offset for the branch.
REQ-013 Jump  input  1  jump decode for the presented instruction.
REQ-014 jump_target  input  26  jump word index.
REQ-015 instruction  output  32  registered instruction to decode.
REQ-016 instr_valid  output  1  instruction is presented and stable.
REQ-017 pc_out  output  32  address of the presented instruction.
REQ-018 pc_plus4  output  32  pc_out + 4, modulo 2^32.

Function
REQ-019 The block SHALL implement the states IDLE, FETCH and HOLD, encoded in 2 bits.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then move to FETCH.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc_out.
REQ-022 In FETCH with imem_ready=1, the block SHALL capture imem_rdata into instruction and move to HOLD.
REQ-023 That capture SHALL raise instr_valid one cycle after imem_ready (minimum latency 1 cycle).
REQ-024 In FETCH with imem_ready=0, the block SHALL stay in FETCH with imem_addr held.
REQ-025 In HOLD, imem_req SHALL be 0, instr_valid SHALL be 1, and instruction and pc_out SHALL be held stable.
REQ-026 Acceptance SHALL occur when state is HOLD and stall=0.
REQ-027 On acceptance, the block SHALL update the PC and move to FETCH, with instr_valid=0 the next cycle.
REQ-028 The next PC SHALL follow this priority:
  - Jump=1: {pc_plus4[31:28], jump_target, 2'b00};
  - else Branch&Zero: pc_plus4 + (sign-extended branch_imm << 2);
  - else: pc_plus4.
REQ-029 Branch, Zero, Jump, branch_imm and jump_target SHALL be ignored outside acceptance.
REQ-030 All PC arithmetic SHALL wrap modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0.
REQ-031 pc_out[1:0] SHALL always be 2'b00; any computed target SHALL have bits [1:0] forced to 0.
REQ-032 imem_ready while imem_req=0 (IDLE or HOLD) SHALL be ignored, with no state or data change.
REQ-033 stall asserted during FETCH SHALL have no effect; it matters only in HOLD.
REQ-034 Sustained throughput SHALL be at most one instruction per 2 cycles.

Reset
REQ-035 While rst_n=0, the block SHALL immediately force: state=IDLE, pc_out=RESET_PC, pc_plus4=RESET_PC+4, instruction=NOP_INSTR, instr_valid=0, imem_req=0, imem_addr=RESET_PC.
REQ-036 A reset asserted mid-FETCH SHALL abandon the outstanding request.
REQ-037 After reset, a late imem_ready SHALL NOT be captured.

Structure
REQ-038 A shared package SHALL hold the state encoding, the RESET_PC default, NOP_INSTR, and the opcode constants shared with the control unit.
REQ-039 One combinational sub-module, next_pc_calc, SHALL compute pc_plus4 and the branch and jump targets and implement the priority mux.
REQ-040 The FSM and the PC/instruction registers SHALL reside in instruction_fetch.

Verification
REQ-041 Reset with imem_ready tied 1 SHALL give: fetch addresses 0x0, 0x4, 0x8 on successive FETCH cycles; instr_valid pattern 0,1,0,1; pc_out matching each fetch address.
REQ-042 Branch=1, Zero=1, branch_imm=16'hFFFE at pc_out=0x100 SHALL give next imem_addr=0xFC; with Zero=0 it SHALL give 0x104.
REQ-043 Jump=1 and Branch=1 together, jump_target=26'h000_0040, pc_out=0x1000_0000 SHALL give next imem_addr=0x1000_0100 (jump wins).
REQ-044 stall=1 for 3 cycles in HOLD SHALL keep instruction, pc_out and instr_valid=1 constant; a branch presented only while stalled SHALL take effect only on the cycle stall falls.
REQ-045 imem_ready low for 4 cycles in FETCH SHALL hold imem_req=1 and a stable address; with RESET_PC=32'hFFFF_FFFC, the next fetch after acceptance SHALL be address 0x0.
REQ-046 rst_n pulsed low mid-FETCH, then imem_ready=1 in the first post-reset cycle, SHALL leave instr_valid=0, the value not captured, and imem_addr=RESET_PC.
